animated_bitmap_renderer: RTL and testbench
===========================================

// Module: animated_bitmap_renderer
// PURPOSE
//  Multi-frame sprite bitmap renderer. It is the parametrised successor of the single-frame object bitmaps.
//  - Stores NUM_FRAMES bitmaps in one ROM.
//  - Steps the animation frame on VGA frame boundaries; supports pixel replication (scaling), horizontal mirror and hide.
//  - Sits between the object's square/bracket block (pixelX/Y offsets, objectExists) and the drawing mux.
// PARAMETERS
//  OBJECT_NUMBER_OF_X_BITS  5      log2 bitmap width (32 px)
//  OBJECT_NUMBER_OF_Y_BITS  5      log2 bitmap height (32 px)
//  NUM_FRAMES               4      animation frames in ROM, >=1
//  FRAME_HOLD               8      VGA frames each animation frame is shown, >=1
//  SCALE_SHIFT              0      each bitmap pixel drawn as 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels
//  LOOP_MODE                1      1 = loop forever; 0 = one-shot, stop on last frame
//  TRANSPARENT_ENCODING     8'hFF  RGB code meaning "do not draw"
// PORTS
//  clk             in   1    pixel clock
//  resetN          in   1    asynchronous active-low reset
//  startOfFrame    in   1    1-cycle pulse per VGA frame
//  pixelX          in   11   offset from object top-left
//  pixelY          in   11   offset from object top-left
//  objectExists    in   1    pixel is inside the object bracket
//  animEnable      in   1    1 = animation advances; 0 = frozen on current frame
//  restartAnim     in   1    pulse: return to frame 0, clear hold count and animDone
//  mirrorX         in   1    1 = draw bitmap flipped left-right
//  hideObject      in   1    1 = force transparent (e.g. item collected)
//  drawingRequest  out  1    RGBout != TRANSPARENT_ENCODING
//  RGBout          out  8    registered pixel color
//  frameIndex      out  FW   current frame, FW = max(1, $clog2(NUM_FRAMES))
//  animWrapPulse   out  1    1-cycle pulse when last frame ends (loop wrap or one-shot stop)
//  animDone        out  1    LOOP_MODE=0 only: set on stop, held until restartAnim; always 0 when LOOP_MODE=1
// BEHAVIOUR
//  Reset (asynchronous, resetN=0):
//   - RGBout=8'hFF, so drawingRequest=0.
//   - frameIndex=0, holdCnt=0, animWrapPulse=0, animDone=0.
//  Pixel path (1-cycle latency):
//   - col = pixelX >> SCALE_SHIFT; row = pixelY >> SCALE_SHIFT.
//   - If mirrorX=1, col' = WIDTH-1-col.
//   - RGBout <= TRANSPARENT when objectExists=0, or hideObject=1, or col >= WIDTH, or row >= HEIGHT.
//     Full 11-bit compare; no index wrap.
//   - Otherwise RGBout <= rom[frameIndex][row][col'].
//   - drawingRequest is combinational from registered RGBout.
//  Animation FSM, 3 states:
//   - FROZEN: animEnable=0. Go to RUN when animEnable=1.
//   - RUN: on each startOfFrame, holdCnt++.
//     - When holdCnt==FRAME_HOLD-1: holdCnt<=0 and the frame advances.
//     - If frameIndex < NUM_FRAMES-1: frameIndex++.
//     - Else, LOOP_MODE=1: frameIndex<=0 and pulse animWrapPulse.
//     - Else, LOOP_MODE=0: stay on the last frame, pulse animWrapPulse, set animDone, go to DONE.
//     - animEnable=0 in RUN: go to FROZEN; holdCnt is kept.
//   - DONE: counters frozen. Leave only on restartAnim; go to RUN if animEnable=1, else FROZEN.
//  Timing and priority:
//   - frameIndex changes only in the cycle after startOfFrame, so a frame never tears mid-scan.
//   - restartAnim has priority over a simultaneous startOfFrame: counters clear, no advance, no pulse.
//   - animWrapPulse is high for exactly one clk.
//   - NUM_FRAMES=1: frameIndex stays 0; the wrap pulse still fires every FRAME_HOLD frames.
//   - Inputs change mid-frame:
//     - mirrorX and hideObject take effect on the next pixel (no frame sync).
//     - animEnable is sampled only at startOfFrame.
//   - Reset mid-animation returns to frame 0 immediately; RGBout is transparent.
// TESTING
//  1. Reset: hold resetN=0 with objectExists=1 -> RGBout=8'hFF, drawingRequest=0, frameIndex=0.
//  2. Pixel lookup (defaults): frame 0, pixelX=5, pixelY=9, objectExists=1 -> next cycle RGBout=rom[0][9][5].
//     Same pixel with mirrorX=1 -> RGBout=rom[0][9][26].
//  3. Scaling and bounds:
//     - SCALE_SHIFT=1, pixelX=11, pixelY=4 -> rom[0][2][5].
//     - pixelX=64 -> 8'hFF.
//     - hideObject=1 on an opaque pixel -> drawingRequest=0 next cycle.
//  4. Loop: animEnable=1, FRAME_HOLD=8, 32 startOfFrame pulses.
//     - frameIndex goes 0->1->2->3->0, changing after pulses 8, 16, 24, 32.
//     - A single animWrapPulse after pulse 32.
//  5. One-shot: LOOP_MODE=0, 40 pulses.
//     - frameIndex stops at 3; animWrapPulse and animDone are set after pulse 32; animDone is held.
//     - restartAnim -> frameIndex=0, animDone=0.
//  6. Simultaneous events and freeze:
//     - restartAnim together with the 8th startOfFrame -> frameIndex=0, holdCnt=0, no pulse.
//     - animEnable=0 for 20 pulses -> frameIndex unchanged.

Source files
------------

// File: rtl/animated_bitmap_renderer.sv
// Multi-frame sprite bitmap renderer: per-pixel lookup into an animated frame set,
// with frame-synchronous animation stepping, pixel replication, mirroring and hide.
module animated_bitmap_renderer #(
  parameter int          OBJECT_NUMBER_OF_X_BITS = 5,
  parameter int          OBJECT_NUMBER_OF_Y_BITS = 5,
  parameter int          NUM_FRAMES              = 4,
  parameter int          FRAME_HOLD              = 8,
  parameter int          SCALE_SHIFT             = 0,
  parameter int          LOOP_MODE               = 1,
  parameter logic [7:0]  TRANSPARENT_ENCODING    = 8'hFF
) (
  input  logic                                                  clk,
  input  logic                                                  resetN,
  input  logic                                                  startOfFrame,
  input  logic [10:0]                                           pixelX,
  input  logic [10:0]                                           pixelY,
  input  logic                                                  objectExists,
  input  logic                                                  animEnable,
  input  logic                                                  restartAnim,
  input  logic                                                  mirrorX,
  input  logic                                                  hideObject,
  output logic                                                  drawingRequest,
  output logic [7:0]                                            RGBout,
  output logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0] frameIndex,
  output logic                                                  animWrapPulse,
  output logic                                                  animDone
);

  localparam int WIDTH  = 1 << OBJECT_NUMBER_OF_X_BITS;
  localparam int HEIGHT = 1 << OBJECT_NUMBER_OF_Y_BITS;
  localparam int FW     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int HW     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  typedef enum logic [1:0] {FROZEN, RUN, DONE} anim_state_t;

  anim_state_t   state;
  logic [HW-1:0] holdCnt;
  logic [10:0]   col;
  logic [10:0]   row;
  logic [10:0]   colM;
  logic          inBounds;

  // Sprite ROM: each frame is a distinct colour gradient, so frame, row and column all matter.
  function automatic logic [7:0] rom_pixel(input logic [FW-1:0] f,
                                           input logic [10:0]   r,
                                           input logic [10:0]   c);
    logic [7:0] fv;
    logic [7:0] rv;
    logic [7:0] cv;
    fv = 8'(f);
    rv = r[7:0];
    cv = c[7:0];
    return fv * 8'd37 + rv * 8'd11 + cv * 8'd3;
  endfunction

  always_comb begin
    col      = pixelX >> SCALE_SHIFT;
    row      = pixelY >> SCALE_SHIFT;
    inBounds = (col < 11'(WIDTH)) && (row < 11'(HEIGHT));
    colM     = mirrorX ? (11'(WIDTH - 1) - col) : col;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      RGBout <= TRANSPARENT_ENCODING;
    else if (!objectExists || hideObject || !inBounds)
      RGBout <= TRANSPARENT_ENCODING;
    else
      RGBout <= rom_pixel(frameIndex, row, colM);
  end

  assign drawingRequest = (RGBout != TRANSPARENT_ENCODING);

  // animEnable is only looked at on startOfFrame, so the frame can never change mid-scan.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= FROZEN;
      frameIndex    <= FW'(0);
      holdCnt       <= HW'(0);
      animWrapPulse <= 1'b0;
      animDone      <= 1'b0;
    end else begin
      animWrapPulse <= 1'b0;
      if (restartAnim) begin
        frameIndex <= FW'(0);
        holdCnt    <= HW'(0);
        animDone   <= 1'b0;
        state      <= animEnable ? RUN : FROZEN;
      end else if (startOfFrame && state != DONE) begin
        if (!animEnable) begin
          state <= FROZEN;
        end else begin
          state <= RUN;
          if (holdCnt == HW'(FRAME_HOLD - 1)) begin
            holdCnt <= HW'(0);
            if (frameIndex != FW'(NUM_FRAMES - 1)) begin
              frameIndex <= frameIndex + FW'(1);
            end else begin
              animWrapPulse <= 1'b1;
              if (LOOP_MODE != 0) begin
                frameIndex <= FW'(0);
              end else begin
                animDone <= 1'b1;
                state    <= DONE;
              end
            end
          end else begin
            holdCnt <= holdCnt + HW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_animated_bitmap_renderer.sv
// Directed bench: a looping unscaled instance (A) and a one-shot 2x-scaled instance (B)
// share all inputs and are checked against hand-computed ROM values and frame sequences.
module tb_animated_bitmap_renderer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        objectExists;
  logic        animEnable;
  logic        restartAnim;
  logic        mirrorX;
  logic        hideObject;

  logic       drA, drB;
  logic [7:0] rgbA, rgbB;
  logic [1:0] frameA, frameB;
  logic       wrapA, wrapB;
  logic       doneA, doneB;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  animated_bitmap_renderer dutA (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .objectExists(objectExists),
    .animEnable(animEnable), .restartAnim(restartAnim), .mirrorX(mirrorX),
    .hideObject(hideObject), .drawingRequest(drA), .RGBout(rgbA),
    .frameIndex(frameA), .animWrapPulse(wrapA), .animDone(doneA)
  );

  animated_bitmap_renderer #(.SCALE_SHIFT(1), .LOOP_MODE(0)) dutB (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .objectExists(objectExists),
    .animEnable(animEnable), .restartAnim(restartAnim), .mirrorX(mirrorX),
    .hideObject(hideObject), .drawingRequest(drB), .RGBout(rgbB),
    .frameIndex(frameB), .animWrapPulse(wrapB), .animDone(doneB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [10:0] x, input logic [10:0] y,
                               input logic exists, input logic mirror, input logic hide);
    pixelX       = x;
    pixelY       = y;
    objectExists = exists;
    mirrorX      = mirror;
    hideObject   = hide;
    tick();
  endtask

  task automatic pixelCheck(input string tag, input logic [10:0] x, input logic [10:0] y,
                            input logic exists, input logic mirror, input logic hide,
                            input logic [7:0] expA, input logic [7:0] expB);
    applyStimulus(x, y, exists, mirror, hide);
    checkOutput({tag, " rgbA"}, 32'(rgbA), 32'(expA));
    checkOutput({tag, " rgbB"}, 32'(rgbB), 32'(expB));
    checkOutput({tag, " drA"}, 32'(drA), 32'(expA != 8'hFF));
  endtask

  task automatic framePulse(input logic restart);
    startOfFrame = 1'b1;
    restartAnim  = restart;
    tick();
    startOfFrame = 1'b0;
    restartAnim  = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; animEnable = 1'b0; restartAnim = 1'b0;
    pixelX = 11'd5; pixelY = 11'd9; objectExists = 1'b1; mirrorX = 1'b0; hideObject = 1'b0;
    tick(); tick();
    checkOutput("reset rgbA", 32'(rgbA), 32'hFF);
    checkOutput("reset drA", 32'(drA), 32'h0);
    checkOutput("reset frameA", 32'(frameA), 32'h0);
    checkOutput("reset wrapA", 32'(wrapA), 32'h0);
    checkOutput("reset doneB", 32'(doneB), 32'h0);
    resetN = 1'b1;
    tick();

    // Expected colours: (frame*37 + row*11 + col*3) mod 256; B uses col/row halved.
    pixelCheck("px 5,9",        11'd5,    11'd9,  1'b1, 1'b0, 1'b0, 8'h72, 8'h32);
    pixelCheck("px 5,9 mirror", 11'd5,    11'd9,  1'b1, 1'b1, 1'b0, 8'hB1, 8'h83);
    pixelCheck("px 11,4",       11'd11,   11'd4,  1'b1, 1'b0, 1'b0, 8'h4D, 8'h25);
    pixelCheck("px 31,9",       11'd31,   11'd9,  1'b1, 1'b0, 1'b0, 8'hC0, 8'h59);
    pixelCheck("px 32,9",       11'd32,   11'd9,  1'b1, 1'b0, 1'b0, 8'hFF, 8'h5C);
    pixelCheck("px 64,4",       11'd64,   11'd4,  1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
    pixelCheck("px 5,32",       11'd5,    11'd32, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hB6);
    pixelCheck("px 5,64",       11'd5,    11'd64, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
    pixelCheck("px 2016,9",     11'd2016, 11'd9,  1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
    pixelCheck("px hide",       11'd5,    11'd9,  1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF);
    pixelCheck("px noexist",    11'd5,    11'd9,  1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
    pixelCheck("px reshow",     11'd5,    11'd9,  1'b1, 1'b0, 1'b0, 8'h72, 8'h32);

    animEnable = 1'b1;
    for (int p = 1; p <= 40; p++) begin
      framePulse(1'b0);
      checkOutput($sformatf("loop p%0d frameA", p), 32'(frameA), 32'((p / 8) % 4));
      checkOutput($sformatf("loop p%0d frameB", p), 32'(frameB), 32'((p / 8 > 3) ? 3 : p / 8));
      checkOutput($sformatf("loop p%0d wrapA", p), 32'(wrapA), 32'(p == 32));
      checkOutput($sformatf("loop p%0d wrapB", p), 32'(wrapB), 32'(p == 32));
      checkOutput($sformatf("loop p%0d doneB", p), 32'(doneB), 32'(p >= 32));
      checkOutput($sformatf("loop p%0d doneA", p), 32'(doneA), 32'h0);
      tick();
      checkOutput($sformatf("loop p%0d wrapA low", p), 32'(wrapA), 32'h0);
      checkOutput($sformatf("loop p%0d wrapB low", p), 32'(wrapB), 32'h0);
    end

    pixelCheck("px late frames", 11'd5, 11'd9, 1'b1, 1'b0, 1'b0, 8'h97, 8'hA1);

    restartAnim = 1'b1;
    tick();
    restartAnim = 1'b0;
    checkOutput("restart frameA", 32'(frameA), 32'h0);
    checkOutput("restart frameB", 32'(frameB), 32'h0);
    checkOutput("restart doneB", 32'(doneB), 32'h0);

    for (int p = 1; p <= 7; p++) framePulse(1'b0);
    checkOutput("pre-collide frameA", 32'(frameA), 32'h0);
    framePulse(1'b1);
    checkOutput("collide frameA", 32'(frameA), 32'h0);
    checkOutput("collide frameB", 32'(frameB), 32'h0);
    checkOutput("collide wrapA", 32'(wrapA), 32'h0);
    for (int p = 1; p <= 7; p++) framePulse(1'b0);
    checkOutput("hold cleared frameA", 32'(frameA), 32'h0);
    framePulse(1'b0);
    checkOutput("advance frameA", 32'(frameA), 32'h1);
    checkOutput("advance frameB", 32'(frameB), 32'h1);

    animEnable = 1'b0;
    for (int p = 1; p <= 20; p++) begin
      framePulse(1'b0);
      checkOutput($sformatf("frozen p%0d frameA", p), 32'(frameA), 32'h1);
    end
    animEnable = 1'b1;
    for (int p = 1; p <= 7; p++) framePulse(1'b0);
    checkOutput("resume7 frameA", 32'(frameA), 32'h1);
    framePulse(1'b0);
    checkOutput("resume8 frameA", 32'(frameA), 32'h2);
    checkOutput("resume8 frameB", 32'(frameB), 32'h2);

    applyStimulus(11'd5, 11'd9, 1'b1, 1'b0, 1'b0);
    checkOutput("pre-reset drA", 32'(drA), 32'h1);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("midreset frameA", 32'(frameA), 32'h0);
    checkOutput("midreset rgbA", 32'(rgbA), 32'hFF);
    checkOutput("midreset drB", 32'(drB), 32'h0);
    tick();
    resetN = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
